// File: rtl/shape_render_ctrl_pkg.sv
// Shared types for the tangram renderer: shape parameter payload and shape kinds.
package shape_render_ctrl_pkg;

  // Fixed-point widths: integer pixel coordinates and trig fraction bits
  localparam int unsigned INT_BITS     = 11;
  localparam int unsigned FLOAT_BITS   = 8;
  // sin/cos span [-1.0, +1.0] in signed Q1.FLOAT_BITS
  localparam int unsigned TRIG_BITS    = FLOAT_BITS + 2;
  localparam int unsigned N_SHAPES_MAX = 16;

  typedef enum logic [1:0] {
    TRI = 2'd0,
    SQR = 2'd1,
    PAR = 2'd2
  } shape_ty_e;

  typedef struct packed {
    shape_ty_e                    ty;
    logic        [INT_BITS-1:0]   size;
    logic signed [TRIG_BITS-1:0]  sin;
    logic signed [TRIG_BITS-1:0]  cos;
    logic signed [INT_BITS-1:0]   ix;
    logic signed [INT_BITS-1:0]   iy;
  } shape_param_t;

endpackage

// File: rtl/shape_render_ctrl_scan_timing.sv
// Raster scan counters with registered line/frame strobes and visible-area decode.
module shape_render_ctrl_scan_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_newframe,
  output logic o_newline,
  output logic o_frame_done,
  output logic o_de_c
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [HW-1:0] w_hcnt_nxt;
  logic [VW-1:0] w_vcnt_nxt;
  logic          w_h_last;
  logic          w_v_last;
  logic          r_last;
  logic          r_newline;

  // Next counter position; strobes are decoded from it so they align with the counters
  always_comb begin
    w_h_last   = (r_hcnt == HW'(H_TOTAL - 1));
    w_v_last   = (r_vcnt == VW'(V_TOTAL - 1));
    w_hcnt_nxt = w_h_last ? '0 : r_hcnt + HW'(1);
    w_vcnt_nxt = r_vcnt;
    if (w_h_last) begin
      w_vcnt_nxt = w_v_last ? '0 : r_vcnt + VW'(1);
    end
  end

  // Counter and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_last    <= 1'b0;
      r_newline <= 1'b0;
    end else begin
      r_hcnt    <= w_hcnt_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_last    <= (w_hcnt_nxt == HW'(H_TOTAL - 1)) && (w_vcnt_nxt == VW'(V_TOTAL - 1));
      r_newline <= (w_hcnt_nxt == HW'(H_TOTAL - 1)) && (w_vcnt_nxt != VW'(V_TOTAL - 1));
    end
  end

  assign o_newframe   = r_last;
  assign o_frame_done = r_last;
  assign o_newline    = r_newline;
  assign o_de_c       = (32'(r_hcnt) < H_ACTIVE) && (32'(r_vcnt) < V_ACTIVE);

endmodule

// File: rtl/shape_render_ctrl.sv
// Sequencer for the render_shape instances: raster strobes, double-buffered
// shape parameter bank with frame-boundary swap, and pixel priority encoder.
module shape_render_ctrl
  import shape_render_ctrl_pkg::*;
#(
  parameter  int unsigned N_SHAPES = 7,
  parameter  int unsigned H_ACTIVE = 640,
  parameter  int unsigned H_TOTAL  = 800,
  parameter  int unsigned V_ACTIVE = 480,
  parameter  int unsigned V_TOTAL  = 525,
  localparam int unsigned IDX_W    = $clog2(N_SHAPES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [IDX_W-1:0]             upd_idx,
  input  shape_param_t                 upd_param,
  input  logic                         upd_commit,
  output logic                         commit_pend,
  output logic                         newframe,
  output logic                         newline,
  output shape_param_t [N_SHAPES-1:0]  shape_param,
  input  logic [N_SHAPES-1:0]          hit,
  output logic                         pix_de,
  output logic                         pix_hit,
  output logic [IDX_W-1:0]             pix_id,
  output logic                         frame_done
);

  logic                        w_newframe;
  logic                        w_newline;
  logic                        w_frame_done;
  logic                        w_de;
  logic                        w_swap;
  logic                        w_wr;
  logic                        r_commit_pend;
  shape_param_t [N_SHAPES-1:0] r_stage;
  shape_param_t [N_SHAPES-1:0] r_active;
  logic [IDX_W-1:0]            w_first_id;
  logic                        r_pix_de;
  logic                        r_pix_hit;
  logic [IDX_W-1:0]            r_pix_id;

  shape_render_ctrl_scan_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_newframe   (w_newframe),
    .o_newline    (w_newline),
    .o_frame_done (w_frame_done),
    .o_de_c       (w_de)
  );

  // Swap happens on the frame's last clock; writes are held off in that cycle
  assign w_swap    = w_newframe && r_commit_pend;
  assign upd_ready = !w_swap;
  assign w_wr      = upd_valid && upd_ready && (32'(upd_idx) < N_SHAPES);

  // Commit flag: a commit coincident with a swap re-arms for the following frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_pend <= 1'b0;
    end else if (upd_commit) begin
      r_commit_pend <= 1'b1;
    end else if (w_swap) begin
      r_commit_pend <= 1'b0;
    end
  end

  // Staging and active banks; staging persists across swaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage  <= '0;
      r_active <= '0;
    end else begin
      if (w_wr) begin
        r_stage[upd_idx] <= upd_param;
      end
      if (w_swap) begin
        r_active <= r_stage;
      end
    end
  end

  // Lowest-index hit wins
  always_comb begin
    w_first_id = '0;
    for (int i = N_SHAPES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        w_first_id = IDX_W'(i);
      end
    end
  end

  // Pixel pipeline, one cycle behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_de  <= 1'b0;
      r_pix_hit <= 1'b0;
      r_pix_id  <= '0;
    end else begin
      r_pix_de  <= w_de;
      r_pix_hit <= w_de && (|hit);
      r_pix_id  <= w_de ? w_first_id : '0;
    end
  end

  assign commit_pend = r_commit_pend;
  assign newframe    = w_newframe;
  assign newline     = w_newline;
  assign frame_done  = w_frame_done;
  assign shape_param = r_active;
  assign pix_de      = r_pix_de;
  assign pix_hit     = r_pix_hit;
  assign pix_id      = r_pix_id;

endmodule

// File: tb/tb_shape_render_ctrl.sv
// Scoreboard bench for shape_render_ctrl on a small 16x6 raster.
`timescale 1ns/1ps
module tb_shape_render_ctrl;
  import shape_render_ctrl_pkg::*;

  localparam int unsigned N     = 7;
  localparam int unsigned HA    = 8;
  localparam int unsigned HT    = 16;
  localparam int unsigned VA    = 4;
  localparam int unsigned VT    = 6;
  localparam int unsigned FL    = HT * VT;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned PW    = $bits(shape_param_t);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  upd_valid;
  logic                  upd_ready;
  logic [IDX_W-1:0]      upd_idx;
  shape_param_t          upd_param;
  logic                  upd_commit;
  logic                  commit_pend;
  logic                  newframe;
  logic                  newline;
  shape_param_t [N-1:0]  shape_param;
  logic [N-1:0]          hit;
  logic                  pix_de;
  logic                  pix_hit;
  logic [IDX_W-1:0]      pix_id;
  logic                  frame_done;

  shape_render_ctrl #(
    .N_SHAPES (N), .H_ACTIVE (HA), .H_TOTAL (HT), .V_ACTIVE (VA), .V_TOTAL (VT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .upd_valid (upd_valid), .upd_ready (upd_ready), .upd_idx (upd_idx),
    .upd_param (upd_param), .upd_commit (upd_commit), .commit_pend (commit_pend),
    .newframe (newframe), .newline (newline), .shape_param (shape_param),
    .hit (hit), .pix_de (pix_de), .pix_hit (pix_hit), .pix_id (pix_id),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 nf;
    logic                 nl;
    logic                 fd;
    logic                 rdy;
    logic                 pend;
    logic                 de;
    logic                 ph;
    logic [IDX_W-1:0]     id;
    shape_param_t [N-1:0] sp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: raster position as a single frame offset
  int unsigned  m_pos;
  logic         m_pend;
  shape_param_t m_stg[N];
  shape_param_t m_act[N];
  int unsigned  rel_cnt;
  bit           nf_seen;
  int unsigned  phase;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_pos   = 0;
    m_pend  = 1'b0;
    rel_cnt = 0;
    nf_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_stg[i] = '0;
      m_act[i] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_newframe"}, 512'(newframe), 512'(0));
    chk({tag, "_newline"}, 512'(newline), 512'(0));
    chk({tag, "_frame_done"}, 512'(frame_done), 512'(0));
    chk({tag, "_pix_de"}, 512'(pix_de), 512'(0));
    chk({tag, "_pix_hit"}, 512'(pix_hit), 512'(0));
    chk({tag, "_pix_id"}, 512'(pix_id), 512'(0));
    chk({tag, "_commit_pend"}, 512'(commit_pend), 512'(0));
    chk({tag, "_shape_param"}, 512'(shape_param), 512'(0));
  endtask

  // Called at a falling edge: drive one cycle of stimulus, predict the next cycle
  task automatic step();
    logic          v;
    logic          cm;
    logic          nf;
    logic          rdy;
    logic          de;
    bit            found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] id;
    logic [PW-1:0] raw;
    shape_param_t  p;
    logic [N-1:0]  h;
    exp_t          e;

    v   = ($urandom_range(0, 3) == 0);
    idx = IDX_W'($urandom_range(0, 7));
    raw = PW'({$urandom(), $urandom()});
    p   = raw;
    cm  = ($urandom_range(0, 59) == 0);
    h   = N'($urandom());
    case (phase)
      1: begin
        cm = (m_pos == 30);
        if (m_pos == 20) begin
          v      = 1'b1;
          idx    = IDX_W'(2);
          p.ty   = SQR;
          p.size = INT_BITS'(4);
          p.sin  = '0;
          p.cos  = TRIG_BITS'(1 << FLOAT_BITS);
          p.ix   = '0;
          p.iy   = '0;
        end
      end
      2: begin
        cm = (m_pos == 40) || (m_pos == FL - 1);
        if (m_pos >= FL - 4) v = 1'b1;
      end
      3: begin
        cm = 1'b0;
        if (m_pos == 0) v = 1'b1;
      end
      default: ;
    endcase
    if (m_pos == 19 || m_pos == 28 || m_pos == 83) h = 7'b0010100;

    upd_valid  = v;
    upd_idx    = idx;
    upd_param  = p;
    upd_commit = cm;
    hit        = h;

    if (!nf_seen && newframe) begin
      nf_seen = 1'b1;
      chk("first_newframe_clk", 512'(rel_cnt), 512'(FL - 1));
    end

    nf  = (m_pos == FL - 1);
    rdy = !(nf && m_pend);
    de  = ((m_pos % HT) < HA) && ((m_pos / HT) < VA);
    if (nf && m_pend) begin
      for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
    end
    if (v && rdy && (32'(idx) < N)) m_stg[idx] = p;
    if (cm) m_pend = 1'b1;
    else if (nf) m_pend = 1'b0;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (h[i] && !found) begin
        id    = IDX_W'(i);
        found = 1'b1;
      end
    end
    e.de = de;
    e.ph = de && (h != '0);
    e.id = de ? id : '0;

    m_pos  = (m_pos + 1) % FL;
    e.nf   = (m_pos == FL - 1);
    e.fd   = e.nf;
    e.nl   = ((m_pos % HT) == HT - 1) && !e.nf;
    e.pend = m_pend;
    e.rdy  = !(e.nf && m_pend);
    for (int i = 0; i < N; i++) e.sp[i] = m_act[i];
    exp_q.push_back(e);

    @(negedge clk);
    rel_cnt++;
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each edge
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("newframe", 512'(newframe), 512'(mon_e.nf));
      chk("newline", 512'(newline), 512'(mon_e.nl));
      chk("frame_done", 512'(frame_done), 512'(mon_e.fd));
      chk("strobe_excl", 512'(newframe && newline), 512'(0));
      chk("upd_ready", 512'(upd_ready), 512'(mon_e.rdy));
      chk("commit_pend", 512'(commit_pend), 512'(mon_e.pend));
      chk("shape_param", 512'(shape_param), 512'(mon_e.sp));
      chk("pix_de", 512'(pix_de), 512'(mon_e.de));
      chk("pix_hit", 512'(pix_hit), 512'(mon_e.ph));
      chk("pix_id", 512'(pix_id), 512'(mon_e.id));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    upd_valid  = 1'b0;
    upd_idx    = '0;
    upd_param  = '0;
    upd_commit = 1'b0;
    hit        = '0;
    phase      = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst_init");

    rst_n = 1'b1;
    model_reset();
    phase = 1; repeat (FL) step();
    chk("newframe_seen_1", 512'(nf_seen), 512'(1));
    phase = 2; repeat (FL) step();
    phase = 3; repeat (FL) step();
    phase = 0; repeat (FL) step();
    while (m_pos != 53) step();

    // Asynchronous reset mid-frame at vcnt=3, hcnt=5
    rst_n      = 1'b0;
    upd_valid  = 1'b0;
    upd_commit = 1'b0;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (FL + 10) step();
    chk("newframe_seen_2", 512'(nf_seen), 512'(1));
    repeat (2 * FL) step();

    upd_valid  = 1'b0;
    upd_commit = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 512'(exp_q.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
